// File: rtl/i2c_pkg.sv
// i2c_pkg -- shared types and constants for the I2C register target.
//   state_t  : protocol FSM states
//   ACK/NACK : bus level of the acknowledge bit
//   RW_READ  : value of the R/W bit that selects a read
//   ack_exit : state that follows the end of an acknowledge slot
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_REG,
    ST_REG_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_WAIT_STOP
  } state_t;

  localparam logic ACK     = 1'b0;
  localparam logic NACK    = 1'b1;
  localparam logic RW_READ = 1'b1;

  // Where the FSM continues once an acknowledge slot has finished.
  function automatic state_t ack_exit(input state_t s);
    case (s)
      ST_ADDR_ACK:               return ST_REG;
      ST_REG_ACK, ST_WDATA_ACK:  return ST_WDATA;
      ST_RDATA_ACK:              return ST_RDATA;
      default:                   return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// i2c_sync_edge -- two-flop synchronizer for one asynchronous bus line plus
// rise/fall detection on the synchronized value.
//   clk     : system clock
//   reset_n : asynchronous active-low reset (flops go to 1 = idle bus)
//   din     : asynchronous bus line
//   level   : synchronized level
//   rise    : one-cycle pulse on a synchronized 0->1 transition
//   fall    : one-cycle pulse on a synchronized 1->0 transition
module i2c_sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  // [0] and [1] form the synchronizer, [2] holds the previous synchronized
  // level for edge detection.
  logic [2:0] sync_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_reg <= 3'b111;
    end else begin
      sync_reg <= {sync_reg[1:0], din};
    end
  end

  assign level = sync_reg[1];
  assign rise  = sync_reg[1] & ~sync_reg[2];
  assign fall  = ~sync_reg[1] & sync_reg[2];

endmodule

// File: rtl/i2c_target.sv
// i2c_target -- I2C target exposing a 256-entry register space through a
// write strobe and a read request/response port.
//   clk_i, reset_ni      : system clock, asynchronous active-low reset
//   scl_i, sda_i         : asynchronous bus inputs
//   sda_oe_o             : 1 pulls SDA low, 0 releases it
//   wr_valid_o/addr/data : one-cycle register write strobe
//   rd_req_o/rd_addr_o   : one-cycle register read request
//   rd_data_i            : read data, sampled the cycle after rd_req_o
//   busy_o               : addressed transaction in progress
// Build option: define I2C_TARGET_READ_EN to support read transfers; without
// it a read address is NACKed and the read port is tied off.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDRESS = 7'h21
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  output logic       wr_valid_o,
  output logic [7:0] wr_addr_o,
  output logic [7:0] wr_data_o,
  output logic       rd_req_o,
  output logic [7:0] rd_addr_o,
  input  logic [7:0] rd_data_i,
  output logic       busy_o
);

`ifdef I2C_TARGET_READ_EN
  localparam logic READ_EN = 1'b1;
`else
  localparam logic READ_EN = 1'b0;
`endif

  logic scl, scl_rise, scl_fall;
  logic sda, sda_rise, sda_fall;

  i2c_sync_edge u_scl_sync (
    .clk     (clk_i),
    .reset_n (reset_ni),
    .din     (scl_i),
    .level   (scl),
    .rise    (scl_rise),
    .fall    (scl_fall)
  );

  i2c_sync_edge u_sda_sync (
    .clk     (clk_i),
    .reset_n (reset_ni),
    .din     (sda_i),
    .level   (sda),
    .rise    (sda_rise),
    .fall    (sda_fall)
  );

  // Both lines share the same synchronizer latency, so a level check of SCL
  // in the cycle of the SDA edge is consistent.
  logic start_det, stop_det;
  assign start_det = sda_fall & scl;
  assign stop_det  = sda_rise & scl;

  state_t     state_reg;
  logic [2:0] bit_cnt_reg;
  logic [6:0] rx_reg;
  logic [7:0] ptr_reg;
  logic       ack_phase_reg;  // first falling edge of the ACK slot seen
  logic       sda_oe_reg;
  logic       busy_reg;
  logic       wr_valid_reg;
  logic [7:0] wr_addr_reg;
  logic [7:0] wr_data_reg;

  // Byte as it stands including the bit sampled on this rising edge.
  logic [7:0] rx_byte;
  logic       last_bit;
  logic       addr_ok;
  assign rx_byte  = {rx_reg, sda};
  assign last_bit = (bit_cnt_reg == 3'd7);
  assign addr_ok  = (rx_byte[7:1] == ADDRESS) && (READ_EN || (rx_byte[0] != RW_READ));

`ifdef I2C_TARGET_READ_EN
  logic       rw_reg;
  logic       rd_req_reg;
  logic [7:0] rd_addr_reg;
  logic       load_reg;     // rd_data_i is valid in this cycle
  logic [6:0] tx_reg;       // remaining bits to shift out after the current one
`endif

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_reg     <= ST_IDLE;
      bit_cnt_reg   <= 3'd0;
      rx_reg        <= 7'd0;
      ptr_reg       <= 8'd0;
      ack_phase_reg <= 1'b0;
      sda_oe_reg    <= 1'b0;
      busy_reg      <= 1'b0;
      wr_valid_reg  <= 1'b0;
      wr_addr_reg   <= 8'd0;
      wr_data_reg   <= 8'd0;
`ifdef I2C_TARGET_READ_EN
      rw_reg        <= 1'b0;
      rd_req_reg    <= 1'b0;
      rd_addr_reg   <= 8'd0;
      load_reg      <= 1'b0;
      tx_reg        <= 7'd0;
`endif
    end else begin
      wr_valid_reg <= 1'b0;
`ifdef I2C_TARGET_READ_EN
      rd_req_reg <= 1'b0;
      load_reg   <= rd_req_reg;
      // First data bit goes out as soon as the response arrives; SCL is
      // still low from the falling edge that issued the request.
      if (load_reg) begin
        tx_reg     <= rd_data_i[6:0];
        sda_oe_reg <= ~rd_data_i[7];
      end
`endif
      if (stop_det) begin
        state_reg     <= ST_IDLE;
        bit_cnt_reg   <= 3'd0;
        ack_phase_reg <= 1'b0;
        sda_oe_reg    <= 1'b0;
        busy_reg      <= 1'b0;
      end else if (start_det) begin
        // Repeated START keeps the register pointer and busy status.
        state_reg     <= ST_ADDR;
        bit_cnt_reg   <= 3'd0;
        ack_phase_reg <= 1'b0;
        sda_oe_reg    <= 1'b0;
      end else begin
        case (state_reg)
          ST_ADDR, ST_REG, ST_WDATA: begin
            if (scl_rise) begin
              rx_reg      <= rx_byte[6:0];
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
              if (last_bit) begin
                if (state_reg == ST_ADDR) begin
                  if (addr_ok) begin
                    state_reg <= ST_ADDR_ACK;
                    busy_reg  <= 1'b1;
`ifdef I2C_TARGET_READ_EN
                    rw_reg    <= rx_byte[0];
`endif
                  end else begin
                    // NACK is presented by leaving SDA released.
                    state_reg  <= ST_WAIT_STOP;
                    busy_reg   <= 1'b0;
                    sda_oe_reg <= ~NACK;
                  end
                end else if (state_reg == ST_REG) begin
                  ptr_reg   <= rx_byte;
                  state_reg <= ST_REG_ACK;
                end else begin
                  wr_valid_reg <= 1'b1;
                  wr_addr_reg  <= ptr_reg;
                  wr_data_reg  <= rx_byte;
                  ptr_reg      <= ptr_reg + 8'd1;
                  state_reg    <= ST_WDATA_ACK;
                end
              end
            end
          end

          ST_ADDR_ACK, ST_REG_ACK, ST_WDATA_ACK: begin
            // Fall #1 starts driving ACK, fall #2 ends the slot.
            if (scl_fall) begin
              if (!ack_phase_reg) begin
                sda_oe_reg    <= ~ACK;
                ack_phase_reg <= 1'b1;
              end else begin
                sda_oe_reg    <= 1'b0;
                ack_phase_reg <= 1'b0;
                bit_cnt_reg   <= 3'd0;
                state_reg     <= ack_exit(state_reg);
`ifdef I2C_TARGET_READ_EN
                if (state_reg == ST_ADDR_ACK && rw_reg == RW_READ) begin
                  state_reg   <= ST_RDATA;
                  rd_req_reg  <= 1'b1;
                  rd_addr_reg <= ptr_reg;
                end
`endif
              end
            end
          end

`ifdef I2C_TARGET_READ_EN
          ST_RDATA: begin
            if (scl_rise) begin
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
              if (last_bit) begin
                state_reg <= ST_RDATA_ACK;
                ptr_reg   <= ptr_reg + 8'd1;
              end
            end else if (scl_fall) begin
              sda_oe_reg <= ~tx_reg[6];
              tx_reg     <= {tx_reg[5:0], 1'b0};
            end
          end

          ST_RDATA_ACK: begin
            // Fall #1 releases SDA for the controller, the rise samples its
            // answer, fall #2 (after an ACK) requests the next byte.
            if (scl_fall) begin
              if (!ack_phase_reg) begin
                sda_oe_reg    <= 1'b0;
                ack_phase_reg <= 1'b1;
              end else begin
                ack_phase_reg <= 1'b0;
                bit_cnt_reg   <= 3'd0;
                state_reg     <= ack_exit(state_reg);
                rd_req_reg    <= 1'b1;
                rd_addr_reg   <= ptr_reg;
              end
            end else if (scl_rise && ack_phase_reg && (sda == NACK)) begin
              state_reg     <= ST_WAIT_STOP;
              ack_phase_reg <= 1'b0;
              busy_reg      <= 1'b0;
            end
          end
`endif

          default: begin
            // IDLE and WAIT_STOP only react to START/STOP above.
          end
        endcase
      end
    end
  end

  assign sda_oe_o   = sda_oe_reg;
  assign busy_o     = busy_reg;
  assign wr_valid_o = wr_valid_reg;
  assign wr_addr_o  = wr_addr_reg;
  assign wr_data_o  = wr_data_reg;

`ifdef I2C_TARGET_READ_EN
  assign rd_req_o  = rd_req_reg;
  assign rd_addr_o = rd_addr_reg;
`else
  logic unused_rd_data;
  assign unused_rd_data = ^rd_data_i;
  assign rd_req_o  = 1'b0;
  assign rd_addr_o = 8'd0;
`endif

endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target -- directed and randomized I2C transactions against a
// transaction-level model (register pointer, register memory, expected
// strobe/request lists). Read tests run when I2C_TARGET_READ_EN is defined.
module tb_i2c_target;

  logic       clk_i = 1'b0;
  logic       reset_ni = 1'b0;
  logic       scl_i = 1'b1;
  logic       ctrl_sda = 1'b1;
  logic       sda_i;
  logic       sda_oe_o;
  logic       wr_valid_o;
  logic [7:0] wr_addr_o;
  logic [7:0] wr_data_o;
  logic       rd_req_o;
  logic [7:0] rd_addr_o;
  logic [7:0] rd_data_i = 8'd0;
  logic       busy_o;

  // Open-drain bus: low if either side pulls it low.
  assign sda_i = ctrl_sda & ~sda_oe_o;

  i2c_target #(.ADDRESS(7'h21)) dut (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .sda_oe_o   (sda_oe_o),
    .wr_valid_o (wr_valid_o),
    .wr_addr_o  (wr_addr_o),
    .wr_data_o  (wr_data_o),
    .rd_req_o   (rd_req_o),
    .rd_addr_o  (rd_addr_o),
    .rd_data_i  (rd_data_i),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int tests = 0;
  int fails = 0;

  // Reference model state.
  logic [7:0]  mem [256];
  int          model_ptr = 0;
  logic [15:0] exp_wr[$];
  logic [7:0]  exp_rd[$];
  logic [15:0] wr_seen[$];
  logic [7:0]  rd_seen[$];
  logic [7:0]  payload[$];

  // Monitor / register-file responder, away from the active edge.
  always @(negedge clk_i) begin
    if (wr_valid_o) wr_seen.push_back({wr_addr_o, wr_data_o});
    if (rd_req_o) begin
      rd_seen.push_back(rd_addr_o);
      rd_data_i = mem[rd_addr_o];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic half();
    repeat (10) @(posedge clk_i);
    #1;
  endtask

  task automatic i2c_start();
    ctrl_sda = 1'b1; half();
    scl_i = 1'b1;    half();
    ctrl_sda = 1'b0; half();
    scl_i = 1'b0;    half();
  endtask

  task automatic i2c_stop();
    ctrl_sda = 1'b0; half();
    scl_i = 1'b1;    half();
    ctrl_sda = 1'b1; half();
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      ctrl_sda = b[i]; half();
      scl_i = 1'b1;    half();
      scl_i = 1'b0;    half();
    end
  endtask

  task automatic write_byte(input logic [7:0] b, output logic acked);
    send_bits(b, 8);
    ctrl_sda = 1'b1; half();
    scl_i = 1'b1;    half();
    acked = ~sda_i;
    scl_i = 1'b0;    half();
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] b);
    ctrl_sda = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      half();
      scl_i = 1'b1; half();
      b[i] = sda_i;
      scl_i = 1'b0;
    end
    half();
    ctrl_sda = nack; half();
    scl_i = 1'b1;    half();
    scl_i = 1'b0;    half();
    ctrl_sda = 1'b1;
  endtask

  task automatic compare_lists(input string tag);
    check({tag, "_wr_count"}, wr_seen.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size() && i < wr_seen.size(); i++)
      check({tag, "_wr"}, wr_seen[i], exp_wr[i]);
    check({tag, "_rd_count"}, rd_seen.size(), exp_rd.size());
    for (int i = 0; i < exp_rd.size() && i < rd_seen.size(); i++)
      check({tag, "_rd"}, rd_seen[i], exp_rd[i]);
    wr_seen.delete(); exp_wr.delete();
    rd_seen.delete(); exp_rd.delete();
  endtask

  // Write transaction: target address, register byte, then payload[].
  task automatic do_write(input logic [6:0] taddr, input logic [7:0] reg_a, input string tag);
    logic ack;
    logic match;
    match = (taddr == 7'h21);
    i2c_start();
    write_byte({taddr, 1'b0}, ack);
    check({tag, "_addr_ack"}, ack, match);
    check({tag, "_busy"}, busy_o, match);
    write_byte(reg_a, ack);
    check({tag, "_reg_ack"}, ack, match);
    if (match) model_ptr = reg_a;
    foreach (payload[i]) begin
      write_byte(payload[i], ack);
      check({tag, "_data_ack"}, ack, match);
      if (match) begin
        exp_wr.push_back({model_ptr[7:0], payload[i]});
        model_ptr = (model_ptr + 1) % 256;
      end
    end
    i2c_stop();
    check({tag, "_idle_busy"}, busy_o, 1'b0);
    $display("[TB] write addr=%02h reg=%02h bytes=%0d ack=%0d", taddr, reg_a, payload.size(), match);
    compare_lists(tag);
  endtask

`ifdef I2C_TARGET_READ_EN
  // Set pointer, repeated START, read n bytes (ACK all but the last).
  task automatic do_read(input logic [7:0] reg_a, input int n, input string tag);
    logic ack;
    logic [7:0] b;
    i2c_start();
    write_byte(8'h42, ack);
    check({tag, "_w_ack"}, ack, 1'b1);
    write_byte(reg_a, ack);
    check({tag, "_reg_ack"}, ack, 1'b1);
    model_ptr = reg_a;
    i2c_start();
    write_byte(8'h43, ack);
    check({tag, "_r_ack"}, ack, 1'b1);
    check({tag, "_busy"}, busy_o, 1'b1);
    for (int i = 0; i < n; i++) begin
      read_byte(i == n - 1, b);
      check({tag, "_rdata"}, b, mem[model_ptr]);
      exp_rd.push_back(model_ptr[7:0]);
      model_ptr = (model_ptr + 1) % 256;
    end
    check({tag, "_nack_busy"}, busy_o, 1'b0);
    check({tag, "_nack_oe"}, sda_oe_o, 1'b0);
    i2c_stop();
    $display("[TB] read reg=%02h bytes=%0d", reg_a, n);
    compare_lists(tag);
  endtask
`endif

  initial begin
    logic ack;
    logic [7:0] r;
    logic [6:0] ta;
    int n;

    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[5] = 8'hA5;

    repeat (5) @(posedge clk_i);
    #1;
    check("rst_oe", sda_oe_o, 1'b0);
    check("rst_wr_valid", wr_valid_o, 1'b0);
    check("rst_rd_req", rd_req_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_wr_addr", wr_addr_o, 8'h00);
    check("rst_wr_data", wr_data_o, 8'h00);
    check("rst_rd_addr", rd_addr_o, 8'h00);
    reset_ni = 1'b1;
    half();

    payload = '{8'h80};
    do_write(7'h21, 8'h12, "basic");
    payload = '{8'h11, 8'h22};
    do_write(7'h21, 8'hFF, "wrap");
    payload = '{8'h55};
    do_write(7'h30, 8'h07, "miss");
    payload = '{8'h3C};
    do_write(7'h21, 8'h40, "after_miss");

    for (int t = 0; t < 6; t++) begin
      ta = ($urandom_range(0, 3) == 0) ? (7'h21 ^ 7'($urandom_range(1, 127))) : 7'h21;
      r = 8'($urandom);
      n = $urandom_range(1, 4);
      payload.delete();
      for (int i = 0; i < n; i++) payload.push_back(8'($urandom));
      do_write(ta, r, "rand_wr");
    end

`ifdef I2C_TARGET_READ_EN
    do_read(8'h05, 1, "read_a5");
    for (int t = 0; t < 3; t++)
      do_read(8'($urandom), $urandom_range(1, 3), "rand_rd");
`else
    i2c_start();
    write_byte(8'h43, ack);
    check("rd_disabled_ack", ack, 1'b0);
    check("rd_disabled_busy", busy_o, 1'b0);
    i2c_stop();
    $display("[TB] read attempt with reads disabled ack=%0d", ack);
    compare_lists("rd_disabled");
`endif

    // Reset while the target is driving the address ACK.
    i2c_start();
    send_bits(8'h42, 8);
    ctrl_sda = 1'b1; half();
    check("ack_driven", sda_oe_o, 1'b1);
    #3 reset_ni = 1'b0;
    #1;
    check("async_release", sda_oe_o, 1'b0);
    check("async_busy", busy_o, 1'b0);
    repeat (3) @(posedge clk_i);
    #1;
    scl_i = 1'b1; ctrl_sda = 1'b1;
    half();
    reset_ni = 1'b1;
    half();
    $display("[TB] reset during ACK slot");
    model_ptr = 0;

    // Reset during the 4th data bit of a write.
    i2c_start();
    write_byte(8'h42, ack);
    check("mid_addr_ack", ack, 1'b1);
    write_byte(8'h9A, ack);
    check("mid_reg_ack", ack, 1'b1);
    send_bits(8'hC6, 3);
    ctrl_sda = 1'b0; half();
    scl_i = 1'b1;    half();
    reset_ni = 1'b0;
    #1;
    check("mid_rst_oe", sda_oe_o, 1'b0);
    check("mid_rst_wr_valid", wr_valid_o, 1'b0);
    repeat (3) @(posedge clk_i);
    #1;
    ctrl_sda = 1'b1;
    half();
    reset_ni = 1'b1;
    half();
    check("mid_rst_wr_addr", wr_addr_o, 8'h00);
    $display("[TB] reset during data bit 4");
    compare_lists("mid_rst");
    model_ptr = 0;

    payload = '{8'hDE, 8'hAD};
    do_write(7'h21, 8'h77, "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i2c_target.md
I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 SHALL have parameter ADDRESS, default 7'h21, the 7-bit target address this block responds to.
REQ-002 SHALL have port clk_i  input  1  system clock (100 MHz nominal); all logic in this domain.
REQ-003 SHALL have port reset_ni  input  1  asynchronous active-low reset.
REQ-004 SHALL have port scl_i  input  1  I2C clock from bus, asynchronous.
REQ-005 SHALL have port sda_i  input  1  I2C data from bus, asynchronous.
REQ-006 SHALL have port sda_oe_o  output  1  open-drain enable; 1 = pull SDA low, 0 = release.
REQ-007 SHALL have port wr_valid_o  output  1  one-cycle strobe, register write.
REQ-008 SHALL have port wr_addr_o  output  8  register address of the write.
REQ-009 SHALL have port wr_data_o  output  8  register data of the write.
REQ-010 SHALL have port rd_req_o  output  1  one-cycle read request.
REQ-011 SHALL have port rd_addr_o  output  8  register address of the read request.
REQ-012 SHALL have port rd_data_i  input  8  read data, valid the cycle after rd_req_o.
REQ-013 SHALL have port busy_o  output  1  high from addressed START until STOP or NACK exit.

Function
REQ-014 SHALL pass scl_i and sda_i through 2-flop synchronizers, then detect rise/fall edges on the synchronized values.
REQ-015 SHALL detect START as synchronized SDA falling while SCL high, and STOP as SDA rising while SCL high.
REQ-016 SHALL sample SDA on SCL rising edges, MSB first; SHALL change sda_oe_o only on SCL falling edges.
REQ-017 SHALL implement states IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP.
REQ-018 IDLE->ADDR on START; after 8 bits, an address match goes to ADDR_ACK (SDA low for one SCL period); a mismatch goes to WAIT_STOP with SDA released.
REQ-019 After the ACK, W goes to REG; the received byte loads the register pointer and goes to REG_ACK, then WDATA.
REQ-020 Each complete WDATA byte SHALL pulse wr_valid_o for one cycle, in the cycle after the 8th SCL rising edge, with wr_addr_o=pointer and wr_data_o=byte; the target SHALL then ACK and increment the pointer modulo 256 (0xFF wraps to 0x00).
REQ-021 After the ACK, R goes to RDATA: rd_req_o pulses with rd_addr_o=pointer on the ADDR_ACK/RDATA_ACK falling edge that ends the ACK; the target shifts rd_data_i out MSB first, then the pointer increments.
REQ-022 In RDATA_ACK the target samples the controller's bit: ACK (0) goes to RDATA; NACK (1) goes to WAIT_STOP.
REQ-023 STOP in any state SHALL go to IDLE with SDA released; a repeated START in any state SHALL go to ADDR, keeping the pointer.
REQ-024 The bit counter SHALL be 3 bits and reset on every START and after every ACK slot.
REQ-025 A START and STOP in the same cycle cannot occur; SCL edges coinciding with START/STOP detection SHALL be ignored.

Reset
REQ-026 On reset_ni low, the block SHALL go to IDLE and set sda_oe_o=0, wr_valid_o=0, rd_req_o=0, busy_o=0, wr_addr_o=0, wr_data_o=0, rd_addr_o=0, pointer=0, and synchronizer flops=1 (idle bus).
REQ-027 Reset mid-transfer SHALL release SDA immediately (asynchronously) and ignore the bus until the next START.

Configuration
REQ-028 With macro I2C_TARGET_READ_EN defined, the block SHALL support reads per REQ-021/022.
REQ-029 Without I2C_TARGET_READ_EN, an address match with R=1 SHALL be NACKed (go to WAIT_STOP), rd_req_o SHALL be tied 0, rd_addr_o tied 0, and rd_data_i ignored.

Structure
REQ-030 Package i2c_pkg SHALL hold the state enum type, the ACK=1'b0/NACK=1'b1 constants and the RW_READ constant.
REQ-031 Sub-module i2c_sync_edge SHALL implement one synchronizer plus rise/fall detect; it is instantiated twice (SCL, SDA).

Verification
REQ-032 Write 0x42(addr 0x21,W), 0x12, 0x80, STOP -> ACK on all three bytes; exactly one wr_valid_o with wr_addr_o=0x12, wr_data_o=0x80.
REQ-033 Write 0x42, 0xFF, 0x11, 0x22 -> strobes (0xFF,0x11) then (0x00,0x22).
REQ-034 Write to address 0x30 -> SDA released during the ACK slot, no strobes, busy_o=0, IDLE after STOP.
REQ-035 With READ_EN, write 0x42, 0x05, repeated START, 0x43, with rd_data_i=0xA5 -> rd_req_o with rd_addr_o=0x05; SDA bits 1010_0101; controller NACK -> WAIT_STOP.
REQ-036 reset_ni asserted during the 4th data bit -> sda_oe_o=0 immediately, no wr_valid_o; the next complete transaction succeeds.
REQ-037 Without READ_EN, 0x43 -> NACK and rd_req_o never asserts.
